// File: rtl/bomb_scheduler.sv
// Bomb placement scheduler: converts two players' place buttons into one-hot slot strobes.
// Optional saturating issue/reject counters are enabled by defining BOMB_SCHED_STATS_EN.
module bomb_scheduler #(
    parameter int unsigned HOLDOFF          = 2,
    parameter int unsigned SLOTS_PER_PLAYER = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            placeP1,
    input  logic                            placeP2,
    input  logic [7:0]                      tileP1,
    input  logic [7:0]                      tileP2,
    input  logic [1:0]                      capP1,
    input  logic [1:0]                      capP2,
    input  logic [2*SLOTS_PER_PLAYER-1:0]   slot_busy,
    input  logic [16*SLOTS_PER_PLAYER-1:0]  slot_tiles,
    output logic [2*SLOTS_PER_PLAYER-1:0]   place_slot,
    output logic [7:0]                      place_tile,
    output logic                            grantP1,
    output logic                            grantP2,
    output logic                            rejectP1,
    output logic                            rejectP2,
`ifdef BOMB_SCHED_STATS_EN
    output logic [7:0]                      issued_cnt,
    output logic [7:0]                      reject_cnt,
`endif
    output logic                            busy
);

    localparam int unsigned NumSlots = 2 * SLOTS_PER_PLAYER;
    localparam int unsigned IdxW     = $clog2(NumSlots);

    typedef enum logic [2:0] {StIdle, StCheck, StIssue, StReject, StHold} state_e;

    state_e               state_q, state_d;
    logic                 pend1_q, pend1_d, pend2_q, pend2_d;
    logic [7:0]           ptile1_q, ptile1_d, ptile2_q, ptile2_d;
    logic                 hist1_q, hist2_q;
    logic                 rr_q, rr_d;
    logic                 sel_q, sel_d;
    logic [7:0]           sel_tile_q, sel_tile_d;
    logic [IdxW-1:0]      slot_q, slot_d;
    logic [3:0]           hold_q, hold_d;
    logic [NumSlots-1:0]  place_slot_q, place_slot_d;
    logic [7:0]           place_tile_q, place_tile_d;
    logic                 grant1_q, grant1_d, grant2_q, grant2_d;
    logic                 reject1_q, reject1_d, reject2_q, reject2_d;

    // Slot occupancy evaluation for the selected player
    int unsigned          cnt;
    int unsigned          cap_eff;
    logic                 occupied;
    logic                 free_found;
    logic [IdxW-1:0]      free_idx;
    logic                 in_range;

    always_comb begin
        cnt        = 0;
        occupied   = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        in_range   = 1'b0;
        cap_eff    = 32'(sel_q ? capP2 : capP1);
        if (cap_eff == 0) begin
            cap_eff = 1;
        end
        for (int i = 0; i < NumSlots; i++) begin
            in_range = sel_q ? (i >= SLOTS_PER_PLAYER) : (i < SLOTS_PER_PLAYER);
            if (slot_busy[i] && (slot_tiles[8*i +: 8] == sel_tile_q)) begin
                occupied = 1'b1;
            end
            if (in_range) begin
                if (slot_busy[i]) begin
                    cnt = cnt + 1;
                end else if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = IdxW'(i);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pend1_d      = pend1_q;
        pend2_d      = pend2_q;
        ptile1_d     = ptile1_q;
        ptile2_d     = ptile2_q;
        rr_d         = rr_q;
        sel_d        = sel_q;
        sel_tile_d   = sel_tile_q;
        slot_d       = slot_q;
        hold_d       = hold_q;
        place_slot_d = '0;
        place_tile_d = '0;
        grant1_d     = 1'b0;
        grant2_d     = 1'b0;
        reject1_d    = 1'b0;
        reject2_d    = 1'b0;

        // Only the first edge of an outstanding request is kept
        if (placeP1 && !hist1_q && !pend1_q) begin
            pend1_d  = 1'b1;
            ptile1_d = tileP1;
        end
        if (placeP2 && !hist2_q && !pend2_q) begin
            pend2_d  = 1'b1;
            ptile2_d = tileP2;
        end

        unique case (state_q)
            StIdle: begin
                if (pend1_q || pend2_q) begin
                    sel_d      = (pend1_q && pend2_q) ? rr_q : pend2_q;
                    sel_tile_d = sel_d ? ptile2_q : ptile1_q;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                slot_d  = free_idx;
                state_d = (cnt < cap_eff && !occupied && free_found) ? StIssue : StReject;
            end
            StIssue: begin
                place_slot_d = NumSlots'(1) << slot_q;
                place_tile_d = sel_tile_q;
                grant1_d     = !sel_q;
                grant2_d     = sel_q;
                if (sel_q) pend2_d = 1'b0;
                else       pend1_d = 1'b0;
                rr_d         = !sel_q;
                hold_d       = '0;
                state_d      = StHold;
            end
            StReject: begin
                reject1_d = !sel_q;
                reject2_d = sel_q;
                if (sel_q) pend2_d = 1'b0;
                else       pend1_d = 1'b0;
                rr_d      = !sel_q;
                hold_d    = '0;
                state_d   = StHold;
            end
            StHold: begin
                if (hold_q == 4'(HOLDOFF)) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            pend1_q      <= 1'b0;
            pend2_q      <= 1'b0;
            ptile1_q     <= '0;
            ptile2_q     <= '0;
            hist1_q      <= 1'b0;
            hist2_q      <= 1'b0;
            rr_q         <= 1'b0;
            sel_q        <= 1'b0;
            sel_tile_q   <= '0;
            slot_q       <= '0;
            hold_q       <= '0;
            place_slot_q <= '0;
            place_tile_q <= '0;
            grant1_q     <= 1'b0;
            grant2_q     <= 1'b0;
            reject1_q    <= 1'b0;
            reject2_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend1_q      <= pend1_d;
            pend2_q      <= pend2_d;
            ptile1_q     <= ptile1_d;
            ptile2_q     <= ptile2_d;
            hist1_q      <= placeP1;
            hist2_q      <= placeP2;
            rr_q         <= rr_d;
            sel_q        <= sel_d;
            sel_tile_q   <= sel_tile_d;
            slot_q       <= slot_d;
            hold_q       <= hold_d;
            place_slot_q <= place_slot_d;
            place_tile_q <= place_tile_d;
            grant1_q     <= grant1_d;
            grant2_q     <= grant2_d;
            reject1_q    <= reject1_d;
            reject2_q    <= reject2_d;
        end
    end

`ifdef BOMB_SCHED_STATS_EN
    logic [7:0] issued_q, reject_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            issued_q <= '0;
            reject_q <= '0;
        end else begin
            if (state_q == StIssue && issued_q != 8'hff) issued_q <= issued_q + 8'd1;
            if (state_q == StReject && reject_q != 8'hff) reject_q <= reject_q + 8'd1;
        end
    end

    assign issued_cnt = issued_q;
    assign reject_cnt = reject_q;
`endif

    assign place_slot = place_slot_q;
    assign place_tile = place_tile_q;
    assign grantP1    = grant1_q;
    assign grantP2    = grant2_q;
    assign rejectP1   = reject1_q;
    assign rejectP2   = reject2_q;
    assign busy       = (state_q != StIdle);

endmodule
